rom_dl_scheduler: RTL and testbench

ROM_DL_SCHEDULER -- requirements
Module: rom_dl_scheduler

---
 rtl/rom_dl_scheduler_if.sv | 14 +
 rtl/rom_dl_scheduler.sv | 139 +++++++++++++
 tb/tb_rom_dl_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_dl_scheduler_if.sv
`default_nettype none
// ---- rom_dl_scheduler_if : SDRAM write port, toggle-handshake (req/ack) -- Rev 1.0 ----
interface rom_dl_scheduler_if;
  logic        req;
  logic        ack;
  logic [21:0] addr;
  logic [15:0] din;
  logic [1:0]  ds;
  logic        we;

  modport master (output req, addr, din, ds, we, input ack);
  modport slave  (input req, addr, din, ds, we, output ack);
endinterface
`default_nettype wire

// File: rtl/rom_dl_scheduler.sv
`default_nettype none
// ---- rom_dl_scheduler : buffers ioctl download bytes into SDRAM writes, gates core reset -- Rev 1.0 ----
module rom_dl_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int RST_STRETCH = 16
) (
  input  logic                clock_48,
  input  logic                reset,
  input  logic                ioctl_downl,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic                reset_req,
  rom_dl_scheduler_if.master  ram,
  output logic                rom_loaded,
  output logic                core_reset,
  output logic                overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (RST_STRETCH < 1) ? 1 : $clog2(RST_STRETCH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [30:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, wr_idx;
  logic [AW:0]     count;
  logic            wr_d, downl_d, loading;
  logic [SW-1:0]   stretch;

  logic            wr_rise, empty, full, pop, push, drop, flush, avail;
  logic            ack_match, load_done;
  logic [30:0]     head;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^ioctl_addr[24:23];

  assign wr_rise   = ioctl_wr & ~wr_d & ioctl_downl;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = (state == ISSUE);
  assign flush     = ioctl_downl & ~downl_d & rom_loaded;
  // A pop or a flush on the same cycle frees a slot for the incoming byte.
  assign push      = wr_rise & (~full | pop | flush);
  assign drop      = wr_rise & ~push;
  assign avail     = ~empty & ~flush;
  assign ack_match = (ram.ack == ram.req);
  assign load_done = loading & ~downl_d & empty & (state == IDLE);
  assign head      = fifo_mem[rd_ptr];
  assign wr_idx    = flush ? '0 : wr_ptr;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (avail) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (ack_match) state_nx = avail ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_48) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock_48) begin
    if (push) fifo_mem[wr_idx] <= {ioctl_addr[22:0], ioctl_dout};
  end

  always_ff @(posedge clock_48) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= {{AW{1'b0}}, push};
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Reset re-synchronises req to ack, abandoning any outstanding request.
  always_ff @(posedge clock_48) begin
    if (reset) begin
      ram.req  <= ram.ack;
      ram.we   <= 1'b0;
      ram.addr <= '0;
      ram.din  <= '0;
      ram.ds   <= '0;
    end else if (state == ISSUE) begin
      ram.addr <= head[30:9];
      ram.din  <= {head[7:0], head[7:0]};
      ram.ds   <= {head[8], ~head[8]};
      ram.we   <= 1'b1;
      ram.req  <= ~ram.req;
    end else if ((state == WAIT) && ack_match && (state_nx == IDLE)) begin
      ram.we   <= 1'b0;
    end
  end

  always_ff @(posedge clock_48) begin
    if (reset) begin
      wr_d       <= 1'b0;
      downl_d    <= 1'b0;
      loading    <= 1'b0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
      stretch    <= '0;
    end else begin
      wr_d    <= ioctl_wr;
      downl_d <= ioctl_downl;
      if (ioctl_downl)    loading <= 1'b1;
      else if (load_done) loading <= 1'b0;
      if (load_done) rom_loaded <= 1'b1;
      if (drop)      overflow   <= 1'b1;
      if (reset_req || load_done) stretch <= SW'(RST_STRETCH);
      else if (stretch != '0)     stretch <= stretch - 1'b1;
    end
  end

  assign core_reset = reset | ~rom_loaded | ioctl_downl | ~empty | (state != IDLE)
                    | reset_req | (stretch != '0);

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_scheduler.sv
`default_nettype none
// ---- tb_rom_dl_scheduler : directed self-checking bench for rom_dl_scheduler -- Rev 1.0 ----
module tb_rom_dl_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_downl;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        reset_req;
  logic        rom_loaded;
  logic        core_reset;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int ack_delay = 3;
  int toggles = 0;
  int log_n = 0;
  logic [21:0] log_addr [64];
  logic [15:0] log_din  [64];
  logic [1:0]  log_ds   [64];

  rom_dl_scheduler_if ram_bus ();

  rom_dl_scheduler #(.FIFO_DEPTH(4), .RST_STRETCH(16)) dut (
    .clock_48    (clk),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .reset_req   (reset_req),
    .ram         (ram_bus),
    .rom_loaded  (rom_loaded),
    .core_reset  (core_reset),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // SDRAM responder: logs every req toggle, answers after ack_delay cycles.
  initial begin
    int   pend;
    logic prev_req;
    pend = 0;
    prev_req = 1'b0;
    ram_bus.ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ram_bus.req !== prev_req) begin
        prev_req = ram_bus.req;
        toggles++;
        if (log_n < 64) begin
          log_addr[log_n] = ram_bus.addr;
          log_din[log_n]  = ram_bus.din;
          log_ds[log_n]   = ram_bus.ds;
          log_n++;
        end
      end
      if (ram_bus.req !== ram_bus.ack) begin
        if (pend >= ack_delay) begin
          ram_bus.ack = ram_bus.req;
          pend = 0;
        end else begin
          pend++;
        end
      end else begin
        pend = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_req_toggle(input string tag, input int limit);
    logic prev;
    logic seen;
    prev = ram_bus.req;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ram_bus.req !== prev) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ram_bus.we === 1'b0 && ram_bus.req === ram_bus.ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_loaded(input string tag, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rom_loaded === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int base_t;
    int base_l;
    int n;

    reset       = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    reset_req   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("core_reset_in_reset", {31'd0, core_reset}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_we",         {31'd0, ram_bus.we}, 32'd0);
    chk("rst_req",        {31'd0, ram_bus.req}, 32'd0);
    chk("rst_addr",       {10'd0, ram_bus.addr}, 32'd0);
    chk("rst_din",        {16'd0, ram_bus.din}, 32'd0);
    chk("rst_ds",         {30'd0, ram_bus.ds}, 32'd0);
    chk("rst_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    chk("rst_overflow",   {31'd0, overflow}, 32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);

    // Single write at byte address 5
    ack_delay = 3;
    ioctl_downl = 1'b1;
    base_t = toggles;
    wr_byte(25'h000005, 8'hA7);
    wait_req_toggle("single_req_toggle", 20);
    chk("single_addr", {10'd0, ram_bus.addr}, 32'h2);
    chk("single_din",  {16'd0, ram_bus.din}, 32'hA7A7);
    chk("single_ds",   {30'd0, ram_bus.ds}, 32'h2);
    chk("single_we",   {31'd0, ram_bus.we}, 32'd1);
    wait_idle("single_back_idle", 40);
    chk("single_toggles", toggles - base_t, 32'd1);

    // Burst of 6 against a slow acknowledge: one in flight, four buffered, one dropped
    ack_delay = 40;
    base_t = toggles;
    base_l = log_n;
    for (int k = 0; k < 6; k++) wr_byte(25'h000010 + 25'(k), 8'h30 + 8'(k));
    chk("burst_overflow", {31'd0, overflow}, 32'd1);
    wait_idle("burst_drain", 1000);
    chk("burst_toggles", toggles - base_t, 32'd5);
    chk("burst_first_addr", {10'd0, log_addr[base_l]}, 32'h08);
    chk("burst_first_din",  {16'd0, log_din[base_l]}, 32'h3030);
    chk("burst_4th_ds",     {30'd0, log_ds[base_l+3]}, 32'h2);
    chk("burst_last_addr",  {10'd0, log_addr[base_l+4]}, 32'h0A);
    chk("burst_last_din",   {16'd0, log_din[base_l+4]}, 32'h3434);
    chk("burst_last_ds",    {30'd0, log_ds[base_l+4]}, 32'h1);

    // Completion with two bytes buffered when downl falls
    ack_delay = 3;
    base_l = log_n;
    wr_byte(25'h000020, 8'h55);
    wr_byte(25'h000021, 8'h66);
    ioctl_downl = 1'b0;
    wait_loaded("load_done_seen", 200);
    chk("load_core_reset_hi", {31'd0, core_reset}, 32'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (core_reset === 1'b0) break;
    end
    chk("stretch_len", n, 32'd16);
    chk("drain_count",   log_n - base_l, 32'd2);
    chk("drain0_addr",   {10'd0, log_addr[base_l]}, 32'h10);
    chk("drain0_din",    {16'd0, log_din[base_l]}, 32'h5555);
    chk("drain1_din",    {16'd0, log_din[base_l+1]}, 32'h6666);
    chk("drain1_ds",     {30'd0, log_ds[base_l+1]}, 32'h2);
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);

    // User reset pulse of one cycle
    @(negedge clk);
    reset_req = 1'b1;
    #1;
    n = (core_reset === 1'b1) ? 1 : 0;
    @(negedge clk);
    reset_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (core_reset !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    chk("user_reset_len", n, 32'd17);
    chk("user_reset_loaded", {31'd0, rom_loaded}, 32'd1);

    // Reload: core_reset follows downl on the same cycle
    @(negedge clk);
    chk("pre_reload_core_reset", {31'd0, core_reset}, 32'd0);
    ioctl_downl = 1'b1;
    #1;
    chk("reload_core_reset", {31'd0, core_reset}, 32'd1);
    chk("reload_loaded",     {31'd0, rom_loaded}, 32'd1);
    ack_delay = 40;
    wr_byte(25'h000007, 8'h99);
    wait_req_toggle("reload_req_toggle", 20);
    chk("reload_addr", {10'd0, ram_bus.addr}, 32'h3);
    chk("reload_din",  {16'd0, ram_bus.din}, 32'h9999);

    // Reset while waiting for the acknowledge
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_we",         {31'd0, ram_bus.we}, 32'd0);
    chk("midrst_req_eq_ack", {31'd0, ram_bus.req === ram_bus.ack}, 32'd1);
    chk("midrst_loaded",     {31'd0, rom_loaded}, 32'd0);
    chk("midrst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("midrst_overflow",   {31'd0, overflow}, 32'd0);
    reset = 1'b0;

    // Fresh request after reset toggles from the re-synchronised req
    ack_delay = 2;
    wr_byte(25'h000001, 8'h3C);
    wait_req_toggle("post_rst_req_toggle", 20);
    chk("post_rst_addr", {10'd0, ram_bus.addr}, 32'h0);
    chk("post_rst_din",  {16'd0, ram_bus.din}, 32'h3C3C);
    chk("post_rst_ds",   {30'd0, ram_bus.ds}, 32'h2);
    ioctl_downl = 1'b0;
    wait_loaded("post_rst_loaded", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
